cksum_sched: RTL and testbench
==============================

# cksum_sched

Sequencer directly upstream of the checksum engine. Holds a small table of checksum jobs (source field start, field length, destination field). For each accepted packet it runs every enabled job in index order through the engine's `start`/`ready` handshake, then reports completion to the downstream stage. Each job is guarded by a timeout so that a stalled engine cannot hang the pipeline.

## Interface
Parameters:
- `NUM_JOBS`, 4: job table depth (1..8).
- `IDX_W`, 2: index width, equal to `$clog2(NUM_JOBS)` with a minimum of 1.
- `TIMEOUT`, 1024: maximum cycles spent waiting on the engine per job.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_we_i` in 1: job-table write strobe.
- `cfg_idx_i` in `IDX_W`: job index to write.
- `cfg_en_i` in 1: job enable bit.
- `cfg_field_start_i` in `` `ADDR_BUS ``: summed-field start address.
- `cfg_field_len_i` in `` `DATA_BUS ``: summed-field length in bytes (even).
- `cfg_dst_i` in `` `ADDR_BUS ``: checksum destination address.
- `cfg_busy_o` out 1: table locked because a packet is in progress.
- `pkt_valid_i` in 1: packet is in memory and ready for checksum.
- `pkt_ready_o` out 1: block is idle and will accept a packet.
- `done_o` out 1: one-cycle pulse when all jobs for the packet are finished.
- `err_o` out 1: valid with `done_o`; 1 if any job timed out.
- `start_o` out 1: start request to the engine.
- `field_start_o` out `` `ADDR_BUS ``: job field start, passed to the engine.
- `field_len_o` out `` `DATA_BUS ``: job field length, passed to the engine.
- `dst_field_start_o` out `` `ADDR_BUS ``: job destination, passed to the engine.
- `cksum_ready_i` in 1: engine ready/finished flag.

## Operation
- **Reset values:** all outputs 0 except `pkt_ready_o`. `pkt_ready_o` is 0 while `rst_n` is low and 1 in the first cycle after release. All job entries are cleared (`en=0`). State is IDLE.
- **Config writes:** a write with `cfg_we_i` applies in IDLE only and is visible to the next accepted packet. Writes while `cfg_busy_o`=1 are dropped silently. A write and a packet accept in the same cycle both take effect, and the packet sees the new entry.
- **IDLE:** `pkt_ready_o`=1. On `pkt_valid_i`:
  - Clear the error flag.
  - Select the lowest-index enabled job and go to ISSUE.
  - If no job is enabled, go to FINISH.
- **ISSUE:**
  - Drive `start_o`=1 and the job fields; they stay stable until RELEASE.
  - Load the timeout counter with `TIMEOUT`.
  - Next cycle go to WAIT_ACK.
- **WAIT_ACK:** wait for `cksum_ready_i`=0, then go to WAIT_DONE. This is needed because the engine keeps ready high from the previous job until it samples start.
- **WAIT_DONE:** wait for `cksum_ready_i`=1, then go to RELEASE.
- **RELEASE:**
  - Drive `start_o`=0 for exactly one cycle so the engine returns to its free state.
  - Then select the next enabled job above the current index and go to ISSUE, or go to FINISH if there is none.
- **FINISH:** pulse `done_o`=1 with `err_o`, then return to IDLE.
- **Timeout:**
  - The counter decrements every cycle in WAIT_ACK and WAIT_DONE.
  - On reaching 0, set the sticky error flag and go to RELEASE; the remaining jobs still run.
  - Reaching timeout and seeing the awaited ready level in the same cycle counts as success.
- **Job selection:** a priority scan over the enable bits, masked by the current index.
- **Reset during a packet:** abandon immediately. No `done_o` is produced. `start_o` drops asynchronously.
- **`cfg_busy_o`:** equals the inverse of `pkt_ready_o` outside reset.

## Timing
- All state, table and output updates happen on the rising edge of `clk`. `rst_n` acts asynchronously.
- Outputs are registered. `pkt_ready_o` and `cfg_busy_o` decode from the state register.
- **Accept to first `start_o`:** 1 cycle (the accept edge moves to ISSUE).
- **Per-job overhead beyond engine latency:** ISSUE, WAIT_ACK≥1 (or 0 extra after reset), and RELEASE 1.
- **Engine latency** for a field of length L: ready rises (L/2)+5 cycles after start is sampled.
- **Last RELEASE to `done_o`:** 1 cycle (the FINISH state).
- **Zero enabled jobs:** `done_o` is asserted 2 cycles after the accept edge.
- **Next accept:** possible in the cycle after `done_o`.

## Structure
- **`def.svh`:**
  - State encodings `` `CKSUM_SCHED_STATE_IDLE/ISSUE/WAIT_ACK/WAIT_DONE/RELEASE/FINISH `` (3 bits).
  - Reuse `` `ADDR_BUS ``, `` `DATA_BUS ``, `` `TRUE ``, `` `FALSE ``, `` `ZERO_ADDR ``, `` `ZERO_WORD ``.
- **Sub-module `cksum_job_pick`:** combinational next-enabled-index finder.
  - Inputs: enable vector and current index.
  - Outputs: `found` and next index.
  - It is instanced twice: once for the first job and once for the next job.

## Test plan
- **Single job:** entry 0 = {en=1, start 0x20, len 4, dst 0x30}, one packet, engine model -> one `start_o` pulse train with fields 0x20/4/0x30, `done_o`=1 with `err_o`=0, 3 cycles after ready rises.
- **Sparse jobs:** jobs 1 and 3 enabled, 0 and 2 disabled -> engine sees job 1 then job 3, each preceded by exactly one RELEASE cycle with `start_o`=0, then one `done_o`.
- **No jobs enabled:** packet accepted -> `done_o` exactly 2 cycles later, `err_o`=0, `start_o` never asserted.
- **Engine timeout:** `TIMEOUT`=16 and the engine never raises ready on job 0, job 1 still healthy -> job 0 aborted after 16 waiting cycles, job 1 runs, `done_o` with `err_o`=1.
- **Config while busy:** write entry 2 during WAIT_DONE -> write ignored and the table is unchanged on the next packet. The same write in IDLE in the accept cycle is used by that packet.
- **Reset mid-job:** `rst_n` low during WAIT_DONE -> `start_o`=0 and `pkt_ready_o`=0 immediately, table cleared. After release, `pkt_ready_o`=1 and there is no `done_o`.

Source files
------------

// File: rtl/cksum_sched_pkg.sv
// Shared types and constants for the checksum job sequencer.
package cksum_sched_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic              TRUE      = 1'b1;
  localparam logic              FALSE     = 1'b0;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RELEASE   = 3'd4,
    ST_FINISH    = 3'd5
  } state_e;

  // One checksum job table entry.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] start;
    logic [DATA_W-1:0] len;
    logic [ADDR_W-1:0] dst;
  } job_t;

endpackage

// File: rtl/cksum_sched_job_pick.sv
// Priority scan: lowest enabled job index above (or, with INCL, at) idx_i.
module cksum_job_pick #(
  parameter int NUM_JOBS = 4,
  parameter int IDX_W    = 2,
  parameter bit INCL     = 1'b0
) (
  input  logic [NUM_JOBS-1:0] en_i,
  input  logic [IDX_W-1:0]    idx_i,
  output logic                found_o,
  output logic [IDX_W-1:0]    idx_o
);

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (en_i[i] && ((i > int'(idx_i)) || (INCL && (i == int'(idx_i))))) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/cksum_sched.sv
// Checksum job sequencer: runs every enabled table entry through the
// engine start/ready handshake per packet, with a per-job timeout.
module cksum_sched
  import cksum_sched_pkg::*;
#(
  parameter int NUM_JOBS = 4,
  parameter int IDX_W    = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic              cfg_en_i,
  input  logic [ADDR_W-1:0] cfg_field_start_i,
  input  logic [DATA_W-1:0] cfg_field_len_i,
  input  logic [ADDR_W-1:0] cfg_dst_i,
  output logic              cfg_busy_o,
  input  logic              pkt_valid_i,
  output logic              pkt_ready_o,
  output logic              done_o,
  output logic              err_o,
  output logic              start_o,
  output logic [ADDR_W-1:0] field_start_o,
  output logic [DATA_W-1:0] field_len_o,
  output logic [ADDR_W-1:0] dst_field_start_o,
  input  logic              cksum_ready_i
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  job_t                tbl_q [NUM_JOBS];
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                load;
  logic                wr_now;
  logic [NUM_JOBS-1:0] en_vec;
  logic                first_found, next_found;
  logic [IDX_W-1:0]    first_idx, next_idx, new_idx;
  job_t                wr_job, new_job;
  logic                start_q, done_q, err_out_q;
  logic [ADDR_W-1:0]   fld_start_q, dst_q;
  logic [DATA_W-1:0]   fld_len_q;

  assign wr_now = cfg_we_i && (state_q == ST_IDLE);
  assign wr_job = '{en: cfg_en_i, start: cfg_field_start_i,
                    len: cfg_field_len_i, dst: cfg_dst_i};

  // Enable vector with an IDLE write forwarded so a same-cycle accept sees it.
  always_comb begin
    en_vec = '0;
    for (int i = 0; i < NUM_JOBS; i++) begin
      en_vec[i] = tbl_q[i].en;
      if (wr_now && (cfg_idx_i == IDX_W'(i))) en_vec[i] = cfg_en_i;
    end
  end

  cksum_job_pick #(.NUM_JOBS(NUM_JOBS), .IDX_W(IDX_W), .INCL(1'b1)) u_pick_first (
    .en_i(en_vec), .idx_i('0), .found_o(first_found), .idx_o(first_idx)
  );

  cksum_job_pick #(.NUM_JOBS(NUM_JOBS), .IDX_W(IDX_W), .INCL(1'b0)) u_pick_next (
    .en_i(en_vec), .idx_i(cur_q), .found_o(next_found), .idx_o(next_idx)
  );

  // Fields of the job about to be issued, again with write forwarding.
  always_comb begin
    new_idx = (state_q == ST_IDLE) ? first_idx : next_idx;
    new_job = tbl_q[new_idx];
    if (wr_now && (cfg_idx_i == new_idx)) new_job = wr_job;
  end

  // Job table: cleared on reset, writable only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_JOBS; i++) tbl_q[i] <= '0;
    end else if (wr_now) begin
      for (int i = 0; i < NUM_JOBS; i++)
        if (cfg_idx_i == IDX_W'(i)) tbl_q[i] <= wr_job;
    end
  end

  // Next-state, timeout and error-flag logic.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    load    = FALSE;
    case (state_q)
      ST_IDLE: if (pkt_valid_i) begin
        err_d = FALSE;
        if (first_found) begin
          state_d = ST_ISSUE;
          cur_d   = first_idx;
          load    = TRUE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_ISSUE: begin
        tmo_d   = TMO_W'(TIMEOUT);
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK, ST_WAIT_DONE: begin
        if (tmo_q != '0) tmo_d = tmo_q - 1'b1;
        // Seeing the awaited level wins over an expiring counter.
        if ((state_q == ST_WAIT_ACK) && !cksum_ready_i) begin
          state_d = ST_WAIT_DONE;
        end else if ((state_q == ST_WAIT_DONE) && cksum_ready_i) begin
          state_d = ST_RELEASE;
        end else if (tmo_q <= TMO_W'(1)) begin
          err_d   = TRUE;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (next_found) begin
          state_d = ST_ISSUE;
          cur_d   = next_idx;
          load    = TRUE;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State, timeout counter and registered engine/downstream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      tmo_q       <= '0;
      err_q       <= FALSE;
      start_q     <= FALSE;
      done_q      <= FALSE;
      err_out_q   <= FALSE;
      fld_start_q <= ZERO_ADDR;
      fld_len_q   <= ZERO_WORD;
      dst_q       <= ZERO_ADDR;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      start_q   <= (state_d == ST_ISSUE) || (state_d == ST_WAIT_ACK) ||
                   (state_d == ST_WAIT_DONE);
      done_q    <= (state_q == ST_FINISH);
      err_out_q <= (state_q == ST_FINISH) && err_q;
      if (load) begin
        fld_start_q <= new_job.start;
        fld_len_q   <= new_job.len;
        dst_q       <= new_job.dst;
      end
    end
  end

  assign pkt_ready_o       = rst_n && (state_q == ST_IDLE);
  assign cfg_busy_o        = (state_q != ST_IDLE);
  assign start_o           = start_q;
  assign done_o            = done_q;
  assign err_o             = err_out_q;
  assign field_start_o     = fld_start_q;
  assign field_len_o       = fld_len_q;
  assign dst_field_start_o = dst_q;

endmodule

// File: tb/tb_cksum_sched.sv
// Scoreboard bench for cksum_sched with a behavioural checksum engine.
module tb_cksum_sched;

  logic        clk, rst_n;
  logic        cfg_we_i, cfg_en_i, pkt_valid_i, cksum_ready_i;
  logic [1:0]  cfg_idx_i;
  logic [31:0] cfg_field_start_i, cfg_field_len_i, cfg_dst_i;
  logic        cfg_busy_o, pkt_ready_o, done_o, err_o, start_o;
  logic [31:0] field_start_o, field_len_o, dst_field_start_o;

  cksum_sched #(.NUM_JOBS(4), .IDX_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_field_start_i(cfg_field_start_i), .cfg_field_len_i(cfg_field_len_i),
    .cfg_dst_i(cfg_dst_i), .cfg_busy_o(cfg_busy_o),
    .pkt_valid_i(pkt_valid_i), .pkt_ready_o(pkt_ready_o),
    .done_o(done_o), .err_o(err_o), .start_o(start_o),
    .field_start_o(field_start_o), .field_len_o(field_len_o),
    .dst_field_start_o(dst_field_start_o), .cksum_ready_i(cksum_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] st, len, dst; int gap, hi; } exp_job_t;
  typedef struct { bit err; bit from_acc; int lat; } exp_done_t;
  exp_job_t  exp_jobs[$];
  exp_done_t exp_done[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: samples start when free, drops ready, raises it len/2+5
  // cycles later and holds it until start falls; start low aborts a job.
  initial begin
    int st, cnt;
    bit stall;
    st = 0; cnt = 0; stall = 1'b0;
    cksum_ready_i = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cksum_ready_i <= 1'b0;
        st = 0;
      end else begin
        case (st)
          0: if (start_o) begin
            cksum_ready_i <= 1'b0;
            cnt   = int'(field_len_o) / 2 + 5;
            stall = (field_start_o == stall_addr);
            st    = 1;
          end
          1: if (!start_o) st = 0;
             else if (!stall) begin
               if (cnt == 1) begin cksum_ready_i <= 1'b1; st = 2; end
               else cnt--;
             end
          default: if (!start_o) st = 0;
        endcase
      end
    end
  end

  // Monitor: pops expectations on start rises and done pulses.
  initial begin
    bit start_prev = 0, rdy_prev = 0;
    int low_run = 0, hi_run = 0, cur_hi = 0, acc_cyc = 0, rise_cyc = 0;
    exp_job_t  ej;
    exp_done_t ed;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        start_prev = 0; low_run = 0; hi_run = 0;
        continue;
      end
      if (cksum_ready_i && !rdy_prev) rise_cyc = cyc;
      if (!cfg_busy_o) low_run = 0;
      else if (!start_o) low_run++;
      if (start_o && !start_prev) begin
        if (exp_jobs.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          ej = exp_jobs.pop_front();
          chk("field_start", field_start_o, ej.st);
          chk("field_len", field_len_o, ej.len);
          chk("dst_field", dst_field_start_o, ej.dst);
          chk("release_gap", low_run, ej.gap);
          cur_hi = ej.hi;
        end
        hi_run = 0;
        low_run = 0;
      end
      if (start_o) hi_run++;
      if (!start_o && start_prev) chk("start_high_cycles", hi_run, cur_hi);
      if (pkt_valid_i && pkt_ready_o) acc_cyc = cyc;
      if (done_o) begin
        if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          ed = exp_done.pop_front();
          chk("err_o", err_o, ed.err);
          chk("done_latency", ed.from_acc ? cyc - acc_cyc : cyc - rise_cyc, ed.lat);
        end
      end
      rdy_prev = cksum_ready_i;
      start_prev = start_o;
    end
  end

  task automatic push_job(input logic [31:0] st, len, dst, input int gap, hi);
    exp_job_t e;
    e.st = st; e.len = len; e.dst = dst; e.gap = gap; e.hi = hi;
    exp_jobs.push_back(e);
  endtask

  task automatic push_done(input bit err, input bit from_acc, input int lat);
    exp_done_t e;
    e.err = err; e.from_acc = from_acc; e.lat = lat;
    exp_done.push_back(e);
  endtask

  task automatic drive_cfg(input bit we, input int idx, input bit en,
                           input logic [31:0] st, len, dst);
    cfg_we_i = we; cfg_idx_i = 2'(idx); cfg_en_i = en;
    cfg_field_start_i = st; cfg_field_len_i = len; cfg_dst_i = dst;
  endtask

  task automatic cfg_wr(input int idx, input bit en, input logic [31:0] st, len, dst);
    @(posedge clk); #1;
    drive_cfg(1'b1, idx, en, st, len, dst);
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic send_pkt;
    @(posedge clk); #1;
    pkt_valid_i = 1'b1;
    @(posedge clk); #1;
    pkt_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done_o) seen = 1;
    end
    if (!seen) chk(nm, 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    pkt_valid_i = 1'b0;
    drive_cfg(1'b0, 0, 1'b0, 0, 0, 0);
    #3;
    chk("rst_pkt_ready", pkt_ready_o, 0);
    chk("rst_start", start_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", cfg_busy_o, 0);
    #19 rst_n = 1'b1;
    #1;
    chk("post_rst_ready", pkt_ready_o, 1);
    chk("post_rst_busy", cfg_busy_o, 0);

    // Single job.
    cfg_wr(0, 1, 32'h20, 4, 32'h30);
    push_job(32'h20, 4, 32'h30, 0, 9);
    push_done(0, 0, 3);
    send_pkt();
    wait_done("single_done_timeout");

    // Sparse jobs 1 and 3.
    cfg_wr(0, 0, 32'h20, 4, 32'h30);
    cfg_wr(1, 1, 32'h100, 6, 32'h110);
    cfg_wr(3, 1, 32'h300, 8, 32'h310);
    push_job(32'h100, 6, 32'h110, 0, 10);
    push_job(32'h300, 8, 32'h310, 1, 11);
    push_done(0, 0, 3);
    send_pkt();
    wait_done("sparse_done_timeout");

    // No jobs enabled.
    cfg_wr(1, 0, 32'h100, 6, 32'h110);
    cfg_wr(3, 0, 32'h300, 8, 32'h310);
    push_done(0, 1, 2);
    send_pkt();
    wait_done("nojob_done_timeout");

    // Engine stalls on job 0; job 1 still runs.
    cfg_wr(0, 1, 32'h40, 4, 32'h50);
    cfg_wr(1, 1, 32'h60, 2, 32'h70);
    stall_addr = 32'h40;
    push_job(32'h40, 4, 32'h50, 0, 17);
    push_job(32'h60, 2, 32'h70, 1, 8);
    push_done(1, 0, 3);
    send_pkt();
    wait_done("timeout_done_timeout");
    stall_addr = 32'hFFFF_FFFF;

    // Write while busy is dropped.
    push_job(32'h40, 4, 32'h50, 0, 9);
    push_job(32'h60, 2, 32'h70, 1, 8);
    push_done(0, 0, 3);
    send_pkt();
    repeat (3) @(posedge clk);
    #1;
    drive_cfg(1'b1, 2, 1'b1, 32'h200, 4, 32'h210);
    chk("busy_in_wait_done", cfg_busy_o, 1);
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    wait_done("busy_wr_done_timeout");

    push_job(32'h40, 4, 32'h50, 0, 9);
    push_job(32'h60, 2, 32'h70, 1, 8);
    push_done(0, 0, 3);
    send_pkt();
    wait_done("after_busy_done_timeout");

    // Same write in the accept cycle is used by that packet.
    push_job(32'h40, 4, 32'h50, 0, 9);
    push_job(32'h60, 2, 32'h70, 1, 8);
    push_job(32'h200, 4, 32'h210, 1, 9);
    push_done(0, 0, 3);
    @(posedge clk); #1;
    drive_cfg(1'b1, 2, 1'b1, 32'h200, 4, 32'h210);
    pkt_valid_i = 1'b1;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
    pkt_valid_i = 1'b0;
    wait_done("accept_wr_done_timeout");

    // Reset during WAIT_DONE of job 0.
    push_job(32'h40, 4, 32'h50, 0, 9);
    send_pkt();
    repeat (4) @(posedge clk);
    #1;
    chk("busy_before_rst", cfg_busy_o, 1);
    exp_jobs.delete();
    exp_done.delete();
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_start", start_o, 0);
    chk("midrst_ready", pkt_ready_o, 0);
    chk("midrst_busy", cfg_busy_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("after_rst_ready", pkt_ready_o, 1);
    repeat (6) @(posedge clk);
    // Table was cleared: the packet finishes with no jobs.
    push_done(0, 1, 2);
    send_pkt();
    wait_done("cleared_done_timeout");

    repeat (3) @(posedge clk);
    chk("exp_jobs_left", exp_jobs.size(), 0);
    chk("exp_done_left", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
